// File: rtl/mimc_pow_sequencer_if.sv
// Operand/result handshake plus the shared Barrett multiplier bus of the MiMC power sequencer.
// The slave view belongs to the sequencer; the master view is the round controller plus multiplier side.
interface mimc_pow_sequencer_if #(
  parameter int N_BITS = 254
);
  logic              in_valid;
  logic              in_ready;
  logic [N_BITS-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [N_BITS-1:0] out_data;
  logic              out_err;
  logic              busy;
  logic              mul_rst;
  logic              mul_en;
  logic [N_BITS-1:0] mul_a;
  logic [N_BITS-1:0] mul_b;
  logic [N_BITS-1:0] mul_product;
  logic              mul_done;

  modport slave (
    input  in_valid, in_data, out_ready, mul_product, mul_done,
    output in_ready, out_valid, out_data, out_err, busy, mul_rst, mul_en, mul_a, mul_b
  );

  modport master (
    output in_valid, in_data, out_ready, mul_product, mul_done,
    input  in_ready, out_valid, out_data, out_err, busy, mul_rst, mul_en, mul_a, mul_b
  );
endinterface

// File: rtl/mimc_pow_sequencer.sv
// MiMC S-box y = x^EXP mod p by left-to-right square-and-multiply on an external Barrett multiplier.
//  state     | meaning
//  IDLE      | waiting for operand, in_ready=1
//  MUL_RST   | multiplier held in reset, operands latched
//  MUL_START | mul_en pulse, timeout counter loaded
//  MUL_WAIT  | waiting for mul_done; exponent-bit decision made on exit
//  STEP      | all exponent bits consumed, result registered
//  OUT       | result (or timeout error) held until out_ready
module mimc_pow_sequencer #(
  parameter int N_BITS  = 254,
  parameter int EXP     = 7,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic rst_n,
  mimc_pow_sequencer_if.slave bus
);

  localparam int              EXP_MSB   = $clog2(EXP + 1) - 1;
  localparam int              CW        = $clog2(TIMEOUT + 1);
  localparam logic [31:0]     EXP_VEC   = 32'(EXP);
  localparam logic [4:0]      IDX_START = 5'(EXP_MSB - 1);
  localparam logic [CW-1:0]   TMO_LOAD  = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_RST,
    S_MUL_START,
    S_MUL_WAIT,
    S_STEP,
    S_OUT
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [N_BITS-1:0] x_q;
  logic [N_BITS-1:0] acc_q;
  logic [N_BITS-1:0] a_q;
  logic [N_BITS-1:0] b_q;
  logic [N_BITS-1:0] out_data_q;
  logic              out_valid_q;
  logic              out_err_q;
  logic              op_mul_q;
  logic [4:0]        bit_idx_q;
  logic [CW-1:0]     tmo_cnt_q;
  logic              exp_bit;
  logic              take_mul;
  logic              last_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A square is followed by a multiply when the current exponent bit is set;
  // otherwise the bit index moves down, and running past bit 0 ends the exponentiation.
  always_comb begin
    state_nxt = state;
    exp_bit   = EXP_VEC[bit_idx_q];
    take_mul  = !op_mul_q && exp_bit;
    last_op   = !take_mul && (bit_idx_q == 5'd0);
    case (state)
      S_IDLE:      if (bus.in_valid) state_nxt = S_MUL_RST;
      S_MUL_RST:   state_nxt = S_MUL_START;
      S_MUL_START: state_nxt = S_MUL_WAIT;
      S_MUL_WAIT: begin
        if (bus.mul_done) begin
          state_nxt = last_op ? S_STEP : S_MUL_RST;
        end else if (tmo_cnt_q == '0) begin
          state_nxt = S_OUT;
        end
      end
      S_STEP:      state_nxt = S_OUT;
      S_OUT:       if (bus.out_ready) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= '0;
      acc_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      op_mul_q    <= 1'b0;
      bit_idx_q   <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            x_q       <= bus.in_data;
            acc_q     <= bus.in_data;
            bit_idx_q <= IDX_START;
            op_mul_q  <= 1'b0;
          end
        end
        S_MUL_RST: begin
          a_q <= acc_q;
          b_q <= op_mul_q ? x_q : acc_q;
        end
        S_MUL_START: begin
          tmo_cnt_q <= TMO_LOAD;
        end
        S_MUL_WAIT: begin
          if (bus.mul_done) begin
            acc_q <= bus.mul_product;
            if (take_mul) begin
              op_mul_q <= 1'b1;
            end else begin
              op_mul_q <= 1'b0;
              if (!last_op) bit_idx_q <= bit_idx_q - 5'd1;
            end
          end else if (tmo_cnt_q == '0) begin
            out_err_q   <= 1'b1;
            out_data_q  <= '0;
            out_valid_q <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q - 1'b1;
          end
        end
        S_STEP: begin
          out_data_q  <= acc_q;
          out_valid_q <= 1'b1;
        end
        S_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Multiplier reset must also follow the system reset without waiting for a clock.
  assign bus.mul_rst   = ~rst_n | (state == S_MUL_RST);
  assign bus.mul_en    = (state == S_MUL_START);
  assign bus.mul_a     = a_q;
  assign bus.mul_b     = b_q;
  assign bus.in_ready  = (state == S_IDLE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_err   = out_err_q;

endmodule
